// File: rtl/fp_subtractor.sv
// Multi-cycle IEEE-754 single-precision subtractor (Difference = operand_1 - operand_2).
// Truncating datapath, denormals flushed to zero, one-bit-per-cycle normaliser.
module fp_subtractor #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [EXP_W+MAN_W:0]     operand_1,
    input  logic [EXP_W+MAN_W:0]     operand_2,
    output logic                     busy,
    output logic                     done,
    output logic [EXP_W+MAN_W:0]     Difference,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;

    localparam logic [EXP_W-1:0] EXP_MAX  = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_TOP  = EXP_MAX - EXP_ONE;
    localparam logic [EXP_W-1:0] MW_E     = EXP_W'(MW);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_SUB   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     diff_q, diff_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic             sign_q, sign_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [MW:0]      mant_q, mant_d;
    logic [MW-1:0]    small_q, small_d;
    logic             eff_sub_q, eff_sub_d;

    // Alignment: operands unpacked, zero/denormal flushed, larger magnitude first
    logic [EXP_W-1:0] ea, eb, big_e, sm_e, shamt;
    logic [MW-1:0]    ma, mb, big_m, sm_m, sm_shift;
    logic             sa, sb, big_s, a_ge_b;
    logic [MW:0]      sum_add, sum_sub, sum_res;

    always_comb begin
        ea       = op_a_q[W-2 -: EXP_W];
        eb       = op_b_q[W-2 -: EXP_W];
        ma       = (ea == '0) ? '0 : {1'b1, op_a_q[MAN_W-1:0]};
        mb       = (eb == '0) ? '0 : {1'b1, op_b_q[MAN_W-1:0]};
        sa       = op_a_q[W-1];
        sb       = ~op_b_q[W-1];
        a_ge_b   = (ea > eb) || ((ea == eb) && (ma >= mb));
        big_e    = a_ge_b ? ea : eb;
        big_m    = a_ge_b ? ma : mb;
        big_s    = a_ge_b ? sa : sb;
        sm_e     = a_ge_b ? eb : ea;
        sm_m     = a_ge_b ? mb : ma;
        shamt    = big_e - sm_e;
        sm_shift = (shamt >= MW_E) ? '0 : (sm_m >> shamt);
        sum_add  = mant_q + {1'b0, small_q};
        sum_sub  = mant_q - {1'b0, small_q};
        sum_res  = eff_sub_q ? sum_sub : sum_add;
    end

    always_comb begin
        state_d   = state_q;
        diff_d    = diff_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        small_d   = small_q;
        eff_sub_d = eff_sub_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_a_d  = operand_1;
                    op_b_d  = operand_2;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if ((ea == EXP_MAX) || (eb == EXP_MAX)) begin
                    diff_d  = QNAN;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    sign_d    = big_s;
                    exp_d     = big_e;
                    mant_d    = {1'b0, big_m};
                    small_d   = sm_shift;
                    eff_sub_d = (sa != sb);
                    state_d   = S_SUB;
                end
            end
            S_SUB: begin
                if (!eff_sub_q && sum_add[MW]) begin
                    if (exp_q == EXP_TOP) begin
                        diff_d  = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
                        ovf_d   = 1'b1;
                        unf_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        mant_d  = sum_add >> 1;
                        exp_d   = exp_q + EXP_ONE;
                        state_d = S_NORM;
                    end
                end else if (sum_res == '0) begin
                    // Exact cancellation always yields +0, whatever the operand signs
                    diff_d  = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    mant_d  = sum_res;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (mant_q[MAN_W]) begin
                    diff_d  = {sign_q, exp_q, mant_q[MAN_W-1:0]};
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_DONE;
                end else if (exp_q <= EXP_ONE) begin
                    diff_d  = {sign_q, {(W-1){1'b0}}};
                    ovf_d   = 1'b0;
                    unf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            diff_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        op_a_q    <= op_a_d;
        op_b_q    <= op_b_d;
        sign_q    <= sign_d;
        exp_q     <= exp_d;
        mant_q    <= mant_d;
        small_q   <= small_d;
        eff_sub_q <= eff_sub_d;
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign Difference = diff_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
endmodule

// File: tb/tb_fp_subtractor.sv
// Scoreboard bench for fp_subtractor: expected results queued at issue, popped at done.
module tb_fp_subtractor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic        busy, done, overflow, underflow;
    logic [31:0] Difference;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] diff;
        logic        ovf;
        logic        unf;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    fp_subtractor #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .operand_1(operand_1), .operand_2(operand_2),
        .busy(busy), .done(done), .Difference(Difference),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Vector table: a, b, expected difference, overflow, underflow, latency (-1 = not timed).
    // 3.0-1.0 subtracts to an already-normalised 2.0, so it takes no shift cycles (latency 3).
    localparam int NV = 16;
    logic [31:0] tv_a [NV] = '{32'h40400000, 32'h3F800000, 32'h40A00000, 32'h3F800000,
                               32'h3FC00000, 32'h3F800000, 32'hC0000000, 32'h3F800000,
                               32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7F7FFFFF,
                               32'h00C00000, 32'h00800000, 32'h7F800000, 32'h3F800000};
    logic [31:0] tv_b [NV] = '{32'h3F800000, 32'hBF800000, 32'h40A00000, 32'h3F7FFFFF,
                               32'h3E800000, 32'h40400000, 32'h3F800000, 32'h3F400000,
                               32'h33000000, 32'h00000001, 32'h3F800000, 32'hFF7FFFFF,
                               32'h00800000, 32'h00C00000, 32'h3F800000, 32'h7FC00001};
    logic [31:0] tv_d [NV] = '{32'h40000000, 32'h40000000, 32'h00000000, 32'h34000000,
                               32'h3FA00000, 32'hC0000000, 32'hC0400000, 32'h3E800000,
                               32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h7F800000,
                               32'h00000000, 32'h80000000, 32'h7FC00000, 32'h7FC00000};
    logic        tv_o [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic        tv_u [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    int          tv_l [NV] = '{3, 3, 2, 26, 3, 3, 3, 5, 3, 3, 3, 2, 3, 3, -1, -1};

    // Called at a negedge; holds start until the DUT takes it, returns at the negedge after.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                         input logic [31:0] ed, input logic eo, input logic eu, input int el,
                         output int waits);
        exp_t e;
        bit   idle;
        waits = 0;
        operand_1 = a;
        operand_2 = b;
        start = 1'b1;
        if (push) begin
            e.diff = ed; e.ovf = eo; e.unf = eu; e.lat = el;
            sb_q.push_back(e);
        end
        for (int i = 0; i < 100; i++) begin
            idle = !busy;
            @(negedge clk);
            waits++;
            if (idle) break;
        end
        start = 1'b0;
    endtask

    task automatic collect(output logic [31:0] d, output logic o, output logic u,
                           output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        d = Difference;
        o = overflow;
        u = underflow;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, overflow, underflow, Difference} !== 36'h0)
            $display("FAIL reset_state got busy=%b done=%b ovf=%b unf=%b diff=%h want all 0",
                     busy, done, overflow, underflow, Difference);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [31:0] d, d_hold;
        logic        o, u;
        int          lat, waits;
        bit          to;
        exp_t        e;
        for (int v = 0; v < NV; v++) begin
            issue(tv_a[v], tv_b[v], 1'b1, tv_d[v], tv_o[v], tv_u[v], tv_l[v], waits);
            collect(d, o, u, lat, to);
            e = sb_q.pop_front();
            n_checks++;
            if (to) $display("FAIL vec%0d_timeout no done within 60 edges", v);
            else n_pass++;
            n_checks++;
            if (d !== e.diff) $display("FAIL vec%0d_diff got %h want %h", v, d, e.diff);
            else n_pass++;
            n_checks++;
            if ({o, u} !== {e.ovf, e.unf})
                $display("FAIL vec%0d_flags got ovf=%b unf=%b want ovf=%b unf=%b",
                         v, o, u, e.ovf, e.unf);
            else n_pass++;
            if (e.lat >= 0) begin
                n_checks++;
                if (lat !== e.lat) $display("FAIL vec%0d_latency got %0d want %0d", v, lat, e.lat);
                else n_pass++;
            end
            @(negedge clk);
            d_hold = Difference;
            n_checks++;
            if ({done, d_hold} !== {1'b0, e.diff})
                $display("FAIL vec%0d_hold got done=%b diff=%h want done=0 diff=%h",
                         v, done, d_hold, e.diff);
            else n_pass++;
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] d;
        logic        o, u;
        int          lat, waits, extra;
        bit          to;
        exp_t        e;
        issue(32'h3FC00000, 32'h3E800000, 1'b1, 32'h3FA00000, 1'b0, 1'b0, 3, waits);
        operand_1 = 32'h40A00000;
        operand_2 = 32'h40A00000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(d, o, u, lat, to);
        e = sb_q.pop_front();
        n_checks++;
        if (to || d !== e.diff || (lat + 1) !== e.lat)
            $display("FAIL busy_ignore_result got diff=%h lat=%0d to=%b want diff=%h lat=%0d",
                     d, lat + 1, to, e.diff, e.lat);
        else n_pass++;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_checks++;
        if (extra != 0 || busy !== 1'b0)
            $display("FAIL busy_ignore_no_second got extra_done=%0d busy=%b want 0 and 0",
                     extra, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        o, u;
        int          lat, waits;
        bit          to;
        exp_t        e;
        issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 3, waits);
        collect(d, o, u, lat, to);
        e = sb_q.pop_front();
        n_checks++;
        if (to || d !== e.diff) $display("FAIL b2b_first got %h want %h", d, e.diff);
        else n_pass++;
        // start raised in the DONE cycle must wait one more edge for IDLE
        issue(32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 1'b0, 5, waits);
        n_checks++;
        if (waits !== 2) $display("FAIL b2b_accept_edges got %0d want 2", waits);
        else n_pass++;
        collect(d, o, u, lat, to);
        e = sb_q.pop_front();
        n_checks++;
        if (to || d !== e.diff || lat !== e.lat)
            $display("FAIL b2b_second got diff=%h lat=%0d want diff=%h lat=%0d",
                     d, lat, e.diff, e.lat);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int waits, seen;
        issue(32'h3F800000, 32'h3F7FFFFF, 1'b0, 32'h0, 1'b0, 1'b0, 0, waits);
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL abort_busy_before got %b want 1", busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, overflow, underflow, Difference} !== 36'h0)
            $display("FAIL abort_reset got busy=%b done=%b ovf=%b unf=%b diff=%h want all 0",
                     busy, done, overflow, underflow, Difference);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL abort_no_done got %0d busy/done cycles want 0", seen);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
